// File: rtl/mat_mult_sched.sv
// Round-robin scheduler sharing one 2x2 8-bit matrix multiply engine among NUM_REQ requesters.
// Operands are latched on grant; the result (or a timeout abort) returns with the requester ID.
module mat_mult_sched #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*32-1:0]      req_mat_a_i,
    input  logic [NUM_REQ*32-1:0]      req_mat_b_i,
    output logic                       eng_start_o,
    output logic [31:0]                eng_mat_a_o,
    output logic [31:0]                eng_mat_b_o,
    input  logic [31:0]                eng_mat_c_i,
    input  logic                       eng_done_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
    output logic [31:0]                rsp_mat_c_o,
    output logic                       rsp_err_o,
    output logic [31:0]                done_cnt_o
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StBusy, StResp, StDrain} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       a_q, a_d, b_q, b_d, c_q, c_d;
    logic [ID_W-1:0]   id_q, id_d, last_grant_q, last_grant_d;
    logic              err_q, err_d;
    logic [31:0]       done_cnt_q, done_cnt_d;

    logic              win_valid;
    logic [ID_W-1:0]   win_idx;
    int unsigned       idx;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_grant_q) + k) % NUM_REQ;
            if (!win_valid && req_valid_i[idx]) begin
                win_valid = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == StIdle && win_valid) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        id_d         = id_q;
        err_d        = err_q;
        done_cnt_d   = done_cnt_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    a_d          = req_mat_a_i[32*win_idx +: 32];
                    b_d          = req_mat_b_i[32*win_idx +: 32];
                    id_d         = win_idx;
                    last_grant_d = win_idx;
                    cnt_d        = '0;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                // Done is checked first so it wins over a coincident timeout.
                if (eng_done_i) begin
                    c_d        = eng_mat_c_i;
                    err_d      = 1'b0;
                    done_cnt_d = done_cnt_q + 32'd1;
                    state_d    = StResp;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    c_d     = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready_i) state_d = StDrain;
            end
            StDrain: begin
                // A lingering done must not complete the next job.
                if (!eng_done_i) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            id_q         <= '0;
            err_q        <= 1'b0;
            done_cnt_q   <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            id_q         <= id_d;
            err_q        <= err_d;
            done_cnt_q   <= done_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign eng_start_o = (state_q == StBusy);
    assign eng_mat_a_o = a_q;
    assign eng_mat_b_o = b_q;
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_id_o    = id_q;
    assign rsp_mat_c_o = c_q;
    assign rsp_err_o   = err_q;
    assign done_cnt_o  = done_cnt_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready_o));
    a_start_busy: assert property (@(posedge clk) disable iff (!rst_n)
        eng_start_o |-> state_q == StBusy);
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid_o && !rsp_ready_i |=> rsp_valid_o && $stable(rsp_id_o)
        && $stable(rsp_mat_c_o) && $stable(rsp_err_o));
endmodule

// File: tb/tb_mat_mult_sched.sv
// Self-checking bench for mat_mult_sched: directed vector table, hand-written corner sequences
// and a randomized phase scored against a plain-arithmetic reference model.
module tb_mat_mult_sched;
    localparam int NR = 3;
    localparam int TO = 16;

    logic               clk, rst_n;
    logic [NR-1:0]      req_valid, req_ready;
    logic [NR*32-1:0]   req_a, req_b;
    logic               eng_start, eng_done;
    logic [31:0]        eng_a, eng_b, eng_c;
    logic               rsp_valid, rsp_ready, rsp_err;
    logic [1:0]         rsp_id;
    logic [31:0]        rsp_c, done_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_done;
    int          eng_lat;
    int          eng_cnt;

    mat_mult_sched #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_mat_a_i(req_a), .req_mat_b_i(req_b),
        .eng_start_o(eng_start), .eng_mat_a_o(eng_a), .eng_mat_b_o(eng_b),
        .eng_mat_c_i(eng_c), .eng_done_i(eng_done),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_mat_c_o(rsp_c), .rsp_err_o(rsp_err), .done_cnt_o(done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] matmul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] c;
        int acc;
        c = '0;
        for (int r = 0; r < 2; r++) begin
            for (int col = 0; col < 2; col++) begin
                acc = 0;
                for (int k = 0; k < 2; k++) begin
                    acc += int'(a[8*(2*r+k) +: 8]) * int'(b[8*(2*k+col) +: 8]);
                end
                c[8*(2*r+col) +: 8] = 8'(acc % 256);
            end
        end
        return c;
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last + k) % NR;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] oh(input int i);
        if (i < 0) return 32'd0;
        return 32'd1 << i;
    endfunction

    // Engine model: done rises eng_lat cycles into start (never if eng_lat==0), drops with start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt  <= 0;
            eng_done <= 1'b0;
        end else if (!eng_start) begin
            eng_cnt  <= 0;
            eng_done <= 1'b0;
        end else begin
            eng_cnt <= eng_cnt + 1;
            if (eng_lat != 0 && eng_cnt + 1 >= eng_lat) eng_done <= 1'b1;
        end
    end
    assign eng_c = eng_done ? matmul(eng_a, eng_b) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        eng_lat   = 1;
        repeat (2) @(negedge clk);
        check("rst start", {31'd0, eng_start}, 32'd0);
        check("rst eng_a", eng_a, 32'd0);
        check("rst rsp", {28'd0, rsp_valid, rsp_err, rsp_id}, 32'd0);
        check("rst rsp_c", rsp_c, 32'd0);
        check("rst done_cnt", done_cnt, 32'd0);
        rst_n    = 1'b1;
        exp_done = '0;
    endtask

    task automatic run_job(input int r, input logic [31:0] a, input logic [31:0] b, input int lat,
                           input logic [31:0] exp_c, input logic exp_err, input int hold,
                           input string tag);
        int n;
        bit leak;
        @(negedge clk);
        eng_lat = lat;
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[r] && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check({tag, " grant"}, 32'(req_ready), oh(r));
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        check({tag, " start"}, {31'd0, eng_start}, 32'd1);
        check({tag, " eng_a"}, eng_a, a);
        n = 0;
        while (!rsp_valid && n < TO + 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " latency"}, 32'(n), exp_err ? 32'(TO) : 32'(lat + 1));
        leak = 1'b0;
        if (hold > 0) begin
            req_valid[(r+1)%NR] = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk); #1;
                if (req_ready != '0 || !rsp_valid) leak = 1'b1;
            end
            check({tag, " hold ready"}, {31'd0, leak}, 32'd0);
        end
        check({tag, " id"}, 32'(rsp_id), 32'(r));
        check({tag, " c"}, rsp_c, exp_c);
        check({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = '0;
        if (!exp_err) exp_done++;
        check({tag, " done_cnt"}, done_cnt, exp_done);
        check({tag, " rsp drop"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    typedef struct {
        int          r;
        logic [31:0] a, b;
        int          lat;
        logic [31:0] c;
        logic        err;
        int          hold;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int n, last, exp_i, completed;
        logic [31:0] q_c[$];
        int          q_id[$];
        req_a = '0;
        req_b = '0;
        vecs[0] = '{0, 32'h0202_0202, 32'h0404_0404, 3, 32'h1010_1010, 1'b0, 0};
        vecs[1] = '{1, 32'h0403_0201, 32'h0807_0605, 1, 32'h322B_1613, 1'b0, 0};
        vecs[2] = '{2, 32'h0100_0001, 32'h0403_0201, 5, 32'h0403_0201, 1'b0, 10};
        vecs[3] = '{0, 32'h8080_8080, 32'h0202_0202, 2, 32'h0000_0000, 1'b0, 0};
        vecs[4] = '{1, 32'h1111_1111, 32'h2222_2222, 0, 32'h0000_0000, 1'b1, 0};
        vecs[5] = '{1, 32'h0101_0101, 32'h0101_0101, 2, 32'h0202_0202, 1'b0, 0};

        do_reset();
        foreach (vecs[i]) begin
            run_job(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].c, vecs[i].err,
                    vecs[i].hold, $sformatf("vec%0d", i));
        end

        // Two requesters contending from reset: strict alternation starting with req 0.
        do_reset();
        eng_lat   = 2;
        rsp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            req_a[31:0]  = 32'h0101_0101 * (j + 1);
            req_a[63:32] = 32'h0101_0101 * (j + 5);
            req_b[63:0]  = {32'h0100_0001, 32'h0100_0001};
            req_valid    = 3'b011;
            #1;
            n = 0;
            while (req_ready == '0 && n < 50) begin
                @(negedge clk); #1; n++;
            end
            check($sformatf("rr grant%0d", j), 32'(req_ready), oh(j % 2));
            @(posedge clk); #1;
            check($sformatf("rr no b2b%0d", j), 32'(req_ready), 32'd0);
            n = 0;
            while (!rsp_valid && n < 40) begin
                @(negedge clk); n++;
            end
            check($sformatf("rr id%0d", j), 32'(rsp_id), 32'(j % 2));
            check($sformatf("rr c%0d", j), rsp_c,
                  32'h0101_0101 * ((j % 2 == 0) ? (j + 1) : (j + 5)));
        end
        rsp_ready = 1'b0;
        req_valid = '0;

        // Asynchronous reset while BUSY: job dropped, req 0 granted first afterwards.
        do_reset();
        run_job(2, 32'h0101_0101, 32'h0101_0101, 1, 32'h0202_0202, 1'b0, 0, "pre");
        @(negedge clk);
        eng_lat = 0;
        req_a[31:0] = 32'h0505_0505;
        req_b[31:0] = 32'h0100_0001;
        req_valid   = 3'b001;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst start", {31'd0, eng_start}, 32'd0);
        check("arst rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        check("arst done_cnt", done_cnt, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_done = '0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("arst no stale rsp", 32'(n), 32'd0);
        eng_lat   = 1;
        req_a[95:32] = {32'h0707_0707, 32'h0606_0606};
        req_b[95:32] = {32'h0100_0001, 32'h0100_0001};
        req_valid = 3'b111;
        #1;
        check("arst first grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk); n++;
        end
        check("arst rsp id", 32'(rsp_id), 32'd0);
        check("arst rsp c", rsp_c, 32'h0505_0505);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_done++;

        // done_cnt wrap: preload all-ones and complete one job.
        @(negedge clk);
        force dut.done_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.done_cnt_q;
        exp_done = 32'hFFFF_FFFF;
        check("wrap preload", done_cnt, exp_done);
        run_job(0, 32'h8080_8080, 32'h0202_0202, 2, 32'h0000_0000, 1'b0, 0, "wrap");

        // Randomized traffic against the reference model.
        do_reset();
        last = NR - 1;
        completed = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    req_a[32*i +: 32] = $urandom;
                    req_b[32*i +: 32] = $urandom;
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = 1'($urandom_range(1));
            #1;
            exp_i = -1;
            if (req_ready != '0) begin
                exp_i = rr_pick(req_valid, last);
                check("rand idle grant", 32'(q_id.size()), 32'd0);
                check("rand rr grant", 32'(req_ready), oh(exp_i));
                if (exp_i >= 0) begin
                    q_id.push_back(exp_i);
                    q_c.push_back(matmul(req_a[32*exp_i +: 32], req_b[32*exp_i +: 32]));
                    last = exp_i;
                    eng_lat = $urandom_range(1, 6);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (q_id.size() == 0) begin
                    check("rand spurious rsp", 32'd1, 32'd0);
                end else begin
                    check("rand rsp id", 32'(rsp_id), 32'(q_id.pop_front()));
                    check("rand rsp c", rsp_c, q_c.pop_front());
                    check("rand rsp err", {31'd0, rsp_err}, 32'd0);
                    completed++;
                    exp_done++;
                end
            end
            @(posedge clk); #1;
            if (exp_i >= 0) req_valid[exp_i] = 1'b0;
        end
        check("rand done_cnt", done_cnt, exp_done);
        check("rand throughput", 32'(completed > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
